// File: rtl/intfmux_pkg.sv
// Shared definitions for the 155/38/4.86 MHz line-interface path:
// scheduler state encoding and the default frame length.
package intfmux_pkg;

  // Default number of iclk38 slots per iclk4d86 frame.
  localparam int PERIOD_DEF = 8;

  // Scheduler state encoding, also visible to the control plane via ostate.
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;
  localparam logic [1:0] ST_FLY    = 2'd2;

  typedef enum logic [1:0] {
    S_HUNT   = ST_HUNT,
    S_LOCKED = ST_LOCKED,
    S_FLY    = ST_FLY
  } sched_state_e;

endpackage

// File: rtl/intfmux_sched.sv
// Slot scheduler for the 38 MHz line-interface mux. Checks the frame sync
// from the sync generator, flywheels across short sync loss, and drives the
// lane mux with lane index, lane-valid, capture strobe and frame marker.
// Every output is registered and decoded from the next state / next phase,
// so it describes the slot the counter is in during the same cycle.
module intfmux_sched
  import intfmux_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,  // slots per frame, 2..8
  parameter int MUX     = 6,           // lanes in slots 0..MUX-1, 1..PERIOD
  parameter int LOSSTHR = 3            // consecutive misses that drop lock, 1..7
) (
  input  logic           iclk38,
  input  logic           rst_,
  input  logic           isyn,
  input  logic [MUX-1:0] ienmask,
  output logic [2:0]     osel,
  output logic           ovalid,
  output logic           ocap,
  output logic           osyn,
  output logic           olock,
  output logic           oslip,
  output logic [1:0]     ostate
);

  sched_state_e state_q, state_d;
  logic [2:0]   ph_q, ph_d;
  logic [2:0]   mc_q, mc_d;

  logic [2:0]   osel_q, osel_d;
  logic         ovalid_q, ovalid_d;
  logic         osyn_q, osyn_d;
  logic         olock_q, olock_d;
  logic         oslip_q, oslip_d;

  logic         ph_last;
  logic         tracking;
  logic         sync_slip;
  logic         miss;
  logic         lost;
  logic [7:0]   mask_ext;

  // Classify this slot's sync event against the expected phase.
  always_comb begin
    ph_last   = (ph_q == 3'(PERIOD - 1));
    tracking  = (state_q != S_HUNT);
    sync_slip = tracking && isyn && !ph_last;
    miss      = tracking && !isyn && ph_last;
    // mc is always 0 in LOCKED, so this also covers the first miss there.
    lost      = miss && ((mc_q + 3'd1) == 3'(LOSSTHR));
  end

  // Next-state logic for the lock state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT: begin
        if (isyn) state_d = S_LOCKED;
      end
      S_LOCKED: begin
        if (lost)      state_d = S_HUNT;
        else if (miss) state_d = S_FLY;
      end
      S_FLY: begin
        if (isyn)      state_d = S_LOCKED;
        else if (lost) state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
  end

  // Next phase: held at 0 while hunting, forced to 0 by any sync, else wraps.
  always_comb begin
    ph_d = ph_q + 3'd1;
    if (!tracking || isyn || ph_last) ph_d = 3'd0;
  end

  // Next miss count: cleared by any sync or loss of lock, bumped per miss.
  always_comb begin
    mc_d = mc_q;
    if (!tracking || isyn || lost) mc_d = 3'd0;
    else if (miss)                 mc_d = mc_q + 3'd1;
  end

  // Output decode from next state / next phase so outputs match the new slot.
  always_comb begin
    mask_ext = 8'(ienmask);
    osel_d   = 3'd0;
    ovalid_d = 1'b0;
    osyn_d   = 1'b0;
    olock_d  = 1'b0;
    oslip_d  = 1'b0;
    if (state_d != S_HUNT) begin
      olock_d = 1'b1;
      oslip_d = sync_slip;
      osyn_d  = (ph_d == 3'd0);
      if ({1'b0, ph_d} < 4'(MUX)) begin
        osel_d   = ph_d;
        ovalid_d = mask_ext[ph_d];
      end
    end
  end

  // Lock state register.
  always_ff @(posedge iclk38 or negedge rst_) begin
    if (!rst_) state_q <= S_HUNT;
    else       state_q <= state_d;
  end

  // Phase counter register.
  always_ff @(posedge iclk38 or negedge rst_) begin
    if (!rst_) ph_q <= 3'd0;
    else       ph_q <= ph_d;
  end

  // Miss counter register.
  always_ff @(posedge iclk38 or negedge rst_) begin
    if (!rst_) mc_q <= 3'd0;
    else       mc_q <= mc_d;
  end

  // Registered mux-facing outputs.
  always_ff @(posedge iclk38 or negedge rst_) begin
    if (!rst_) begin
      osel_q   <= 3'd0;
      ovalid_q <= 1'b0;
      osyn_q   <= 1'b0;
      olock_q  <= 1'b0;
      oslip_q  <= 1'b0;
    end else begin
      osel_q   <= osel_d;
      ovalid_q <= ovalid_d;
      osyn_q   <= osyn_d;
      olock_q  <= olock_d;
      oslip_q  <= oslip_d;
    end
  end

  assign osel   = osel_q;
  assign ovalid = ovalid_q;
  assign ocap   = osyn_q;
  assign osyn   = osyn_q;
  assign olock  = olock_q;
  assign oslip  = oslip_q;
  assign ostate = state_q;

endmodule

// File: tb/tb_intfmux_sched.sv
// Directed bench for intfmux_sched: a table of per-cycle {inputs, expected
// outputs} rows for the default build (PERIOD=8, MUX=6, LOSSTHR=3), plus
// hand-written sequences for async mid-frame reset and a PERIOD=MUX=6 build.
// Each row's inputs are held across one rising edge; the expected outputs
// are those seen just after that edge.
module tb_intfmux_sched;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       isyn = 1'b0;
  logic [5:0] mask = 6'h3F;
  logic [2:0] osel;
  logic       ovalid, ocap, osyn, olock, oslip;
  logic [1:0] ostate;

  logic       isyn6 = 1'b0;
  logic [5:0] mask6 = 6'h3F;
  logic [2:0] osel6;
  logic       ovalid6, ocap6, osyn6, olock6, oslip6;
  logic [1:0] ostate6;

  intfmux_sched #(.PERIOD(8), .MUX(6), .LOSSTHR(3)) dut (
    .iclk38 (clk),
    .rst_   (rst_n),
    .isyn   (isyn),
    .ienmask(mask),
    .osel   (osel),
    .ovalid (ovalid),
    .ocap   (ocap),
    .osyn   (osyn),
    .olock  (olock),
    .oslip  (oslip),
    .ostate (ostate)
  );

  intfmux_sched #(.PERIOD(6), .MUX(6), .LOSSTHR(3)) dut6 (
    .iclk38 (clk),
    .rst_   (rst_n),
    .isyn   (isyn6),
    .ienmask(mask6),
    .osel   (osel6),
    .ovalid (ovalid6),
    .ocap   (ocap6),
    .osyn   (osyn6),
    .olock  (olock6),
    .oslip  (oslip6),
    .ostate (ostate6)
  );

  // Output vector layout: {osel[2:0], ovalid, ocap, osyn, olock, oslip, ostate[1:0]}
  function automatic logic [9:0] ex(input logic [2:0] sel, input logic v,
                                    input logic s, input logic l,
                                    input logic sl, input logic [1:0] st);
    return {sel, v, s, s, l, sl, st};
  endfunction

  wire [9:0] act  = {osel,  ovalid,  ocap,  osyn,  olock,  oslip,  ostate};
  wire [9:0] act6 = {osel6, ovalid6, ocap6, osyn6, olock6, oslip6, ostate6};

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       isyn;
    logic [5:0] mask;
    logic [9:0] exp;
  } vec_t;

  vec_t       vec_q[$];
  logic [9:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  // Slots 1..7 of a tracking frame with mask 6'h3F, hand-tabulated.
  logic [2:0] tail_sel [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
  logic       tail_val [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [9:0] a, input logic [9:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got sel=%0d val=%b cap=%b syn=%b lock=%b slip=%b st=%0d, want sel=%0d val=%b cap=%b syn=%b lock=%b slip=%b st=%0d",
               name, a[9:7], a[6], a[5], a[4], a[3], a[2], a[1:0],
               e[9:7], e[6], e[5], e[4], e[3], e[2], e[1:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add(input logic s, input logic [5:0] m, input logic [9:0] e);
    vec_t v;
    v.isyn = s;
    v.mask = m;
    v.exp  = e;
    vec_q.push_back(v);
  endtask

  task automatic add_hunt(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 6'h3F, 10'd0);
  endtask

  // Push n no-sync rows continuing a frame from slot 1 (n <= 7).
  task automatic add_tail(input logic [1:0] st, input int n);
    for (int p = 1; p <= n; p++)
      add(1'b0, 6'h3F, ex(tail_sel[p], tail_val[p], 1'b0, 1'b1, 1'b0, st));
  endtask

  task automatic step_main(input logic s, input logic [5:0] m);
    isyn = s;
    mask = m;
    @(posedge clk);
    #1;
    isyn = 1'b0;
  endtask

  task automatic step6(input logic s, input logic [5:0] m);
    isyn6 = s;
    mask6 = m;
    @(posedge clk);
    #1;
    isyn6 = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    // Acquisition: hunt, sync at cycle 10, then a full frame and aligned sync.
    add_hunt(10);
    add(1'b1, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    add_tail(2'd1, 7);
    add(1'b1, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    // Slip: sync during slot 4, three slots early.
    add_tail(2'd1, 4);
    add(1'b1, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1));
    add_tail(2'd1, 7);
    add(1'b1, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    // Flywheel over two misses, then aligned recovery.
    add_tail(2'd1, 7);
    add(1'b0, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2));
    add_tail(2'd2, 7);
    add(1'b0, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2));
    add_tail(2'd2, 7);
    add(1'b1, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    // Loss after three consecutive misses.
    add_tail(2'd1, 7);
    add(1'b0, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2));
    add_tail(2'd2, 7);
    add(1'b0, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2));
    add_tail(2'd2, 7);
    add(1'b0, 6'h3F, 10'd0);
    add_hunt(2);
    // Relock, then mask changes mid-frame.
    add(1'b1, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    add(1'b0, 6'b101010, ex(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
    add(1'b0, 6'b101010, ex(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
    add(1'b0, 6'b101010, ex(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
    add(1'b0, 6'b010101, ex(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
    add(1'b0, 6'b010101, ex(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
    add(1'b0, 6'b010101, ex(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
    add(1'b0, 6'b010101, ex(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
    add(1'b1, 6'h3F, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    add_tail(2'd1, 2);

    // Reset state, both builds.
    repeat (3) @(posedge clk);
    #1;
    check("reset_main", act, 10'd0);
    check("reset_p6", act6, 10'd0);
    rst_n = 1'b1;

    // Table-driven pass.
    foreach (vec_q[i]) exp_q.push_back(vec_q[i].exp);
    for (int i = 0; i < vec_q.size(); i++) begin
      step_main(vec_q[i].isyn, vec_q[i].mask);
      check($sformatf("row%0d", i), act, exp_q.pop_front());
    end

    // Mid-frame asynchronous reset (main build is locked, slot 2).
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_main", act, 10'd0);
    check("async_reset_p6", act6, 10'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_main(1'b0, 6'h3F);
    check("post_reset_no_sync", act, 10'd0);
    step_main(1'b1, 6'h3F);
    check("post_reset_relock", act, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));

    // PERIOD=MUX=6 build: no idle slots.
    step6(1'b1, 6'h3F);
    check("p6_acq", act6, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    for (int p = 1; p <= 4; p++) begin
      step6(1'b0, 6'h3F);
      check($sformatf("p6_slot%0d", p), act6, ex(3'(p), 1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
    end
    step6(1'b0, 6'h3F);
    check("p6_slot5", act6, ex(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
    step6(1'b1, 6'h3F);
    check("p6_aligned", act6, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
    for (int p = 1; p <= 4; p++) step6(1'b0, 6'h3F);
    step6(1'b0, 6'h1F);
    check("p6_slot5_masked", act6, ex(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
    step6(1'b0, 6'h3F);
    check("p6_miss_fly", act6, ex(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
